// File: rtl/uart_rx.sv
// 8N1 UART receiver with configurable input synchronizer and per-frame latched baud divisor.
// Define UART_RX_FRAMING_ERR_EN to add the framing_err pulse output.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count,
  input  logic       serial_in,
  output logic       rx_active,
  output logic       rx_done,
  output logic [7:0] data_byte
`ifdef UART_RX_FRAMING_ERR_EN
  ,
  output logic       framing_err
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [7:0]             timer, timer_n;
  logic [2:0]             bit_idx, bit_idx_n;
  logic [7:0]             shift, shift_n;
  logic [7:0]             div, div_n;
  logic [7:0]             byte_n;
  logic                   active_n;
  logic                   done_n;
  logic                   fe_n;
  logic                   armed, armed_n;
  logic [7:0]             half_m1;
  logic [7:0]             div_m1;

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign half_m1 = (div >> 1) - 8'd1;
  assign div_m1  = div - 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= 8'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      div       <= 8'd2;
      data_byte <= 8'd0;
      rx_active <= 1'b0;
      rx_done   <= 1'b0;
      armed     <= 1'b1;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      div       <= div_n;
      data_byte <= byte_n;
      rx_active <= active_n;
      rx_done   <= done_n;
      armed     <= armed_n;
    end
  end

`ifdef UART_RX_FRAMING_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      framing_err <= 1'b0;
    end else begin
      framing_err <= fe_n;
    end
  end
`endif

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    div_n     = div;
    byte_n    = data_byte;
    active_n  = rx_active;
    done_n    = 1'b0;
    fe_n      = 1'b0;
    case (state)
      IDLE: begin
        // armed blocks re-triggering on a line still held low after a framing error
        if (!rxs && armed) begin
          timer_n  = 8'd0;
          div_n    = (count < 8'd2) ? 8'd2 : count;
          active_n = 1'b1;
          state_n  = START;
        end
      end
      START: begin
        if (timer == half_m1) begin
          timer_n = 8'd0;
          if (!rxs) begin
            bit_idx_n = 3'd0;
            state_n   = DATA;
          end else begin
            active_n = 1'b0;
            state_n  = IDLE;
          end
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      DATA: begin
        if (timer == div_m1) begin
          timer_n = 8'd0;
          shift_n = {rxs, shift[7:1]};
          if (bit_idx == 3'd7) begin
            bit_idx_n = 3'd0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      STOP: begin
        if (timer == div_m1) begin
          timer_n = 8'd0;
          if (rxs) begin
            byte_n = shift;
            done_n = 1'b1;
          end else begin
            fe_n = 1'b1;
          end
          state_n = CLEANUP;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      CLEANUP: begin
        active_n = 1'b0;
        state_n  = IDLE;
      end
      default: begin
        active_n = 1'b0;
        state_n  = IDLE;
      end
    endcase
    armed_n = armed;
    if (rxs) armed_n = 1'b1;
    if (fe_n) armed_n = 1'b0;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, glitch, framing error with break, back-to-back,
// mid-frame reset and minimum divisor.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic [7:0] count;
  logic       serial_in;
  logic       rx_active;
  logic       rx_done;
  logic [7:0] data_byte;
`ifdef UART_RX_FRAMING_ERR_EN
  logic       framing_err;
  int         fe_cnt = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int         done_cnt   = 0;
  int         active_cnt = 0;
  logic [7:0] got_bytes [64];
  logic [7:0] exp_q [$];

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .serial_in (serial_in),
    .rx_active (rx_active),
    .rx_done   (rx_done),
    .data_byte (data_byte)
`ifdef UART_RX_FRAMING_ERR_EN
    ,
    .framing_err (framing_err)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      got_bytes[done_cnt % 64] = data_byte;
      done_cnt = done_cnt + 1;
    end
    if (rx_active === 1'b1) active_cnt = active_cnt + 1;
`ifdef UART_RX_FRAMING_ERR_EN
    if (framing_err === 1'b1) fe_cnt = fe_cnt + 1;
`endif
  end

  task automatic send_byte(input logic [7:0] b, input logic stop, input int cpb);
    serial_in = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (cpb) @(negedge clk);
    end
    serial_in = stop;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    serial_in = 1'b1;
    count = 8'd50;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b expected 0", rx_active); end
    n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", rx_done); end
    n_cmp++; if (data_byte !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", data_byte); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // 0x55 at 50 cycles/bit; count changes mid-frame and must be ignored
  task automatic test_basic;
    int d0, a0;
    d0 = done_cnt;
    a0 = active_cnt;
    fork
      send_byte(8'h55, 1'b1, 50);
      begin
        repeat (100) @(negedge clk);
        count = 8'd7;
      end
    join
    repeat (30) @(negedge clk);
    count = 8'd50;
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (data_byte !== 8'h55) begin n_err++; $display("FAIL basic_data: got %h expected 55", data_byte); end
    n_cmp++; if (active_cnt - a0 !== 476) begin n_err++; $display("FAIL basic_active_cycles: got %0d expected 476", active_cnt - a0); end
    n_cmp++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL basic_active_end: got %b expected 0", rx_active); end
  endtask

  task automatic test_glitch;
    int d0, a0;
    d0 = done_cnt;
    a0 = active_cnt;
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    repeat (80) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL glitch_done: got %0d expected 0", done_cnt - d0); end
    n_cmp++; if (active_cnt - a0 !== 25) begin n_err++; $display("FAIL glitch_active_cycles: got %0d expected 25", active_cnt - a0); end
    n_cmp++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL glitch_active_end: got %b expected 0", rx_active); end
    n_cmp++; if (data_byte !== 8'h55) begin n_err++; $display("FAIL glitch_data: got %h expected 55", data_byte); end
  endtask

  // bad stop bit, then line held low as a break; no restart until it goes high
  task automatic test_framing;
    int d0, a0;
`ifdef UART_RX_FRAMING_ERR_EN
    int f0;
    f0 = fe_cnt;
`endif
    d0 = done_cnt;
    send_byte(8'hA3, 1'b0, 50);
    a0 = active_cnt;
    repeat (200) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL framing_done: got %0d expected 0", done_cnt - d0); end
    n_cmp++; if (data_byte !== 8'h55) begin n_err++; $display("FAIL framing_data: got %h expected 55", data_byte); end
    n_cmp++; if (active_cnt - a0 !== 0) begin n_err++; $display("FAIL break_guard_active: got %0d expected 0", active_cnt - a0); end
`ifdef UART_RX_FRAMING_ERR_EN
    n_cmp++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL framing_err_pulses: got %0d expected 1", fe_cnt - f0); end
`endif
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h5A, 1'b1, 50);
    repeat (30) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL framing_recover_done: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (data_byte !== 8'h5A) begin n_err++; $display("FAIL framing_recover_data: got %h expected 5a", data_byte); end
  endtask

  task automatic test_back_to_back;
    int d0;
    logic [7:0] e;
    count = 8'd16;
    d0 = done_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1, 16);
    send_byte(8'hFF, 1'b1, 16);
    repeat (30) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_bytes[(d0 + i) % 64] !== e) begin
        n_err++;
        $display("FAIL b2b_byte%0d: got %h expected %h", i, got_bytes[(d0 + i) % 64], e);
      end
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    logic [7:0] b;
    b = 8'h3C;
    d0 = done_cnt;
    serial_in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial_in = b[i];
      repeat (16) @(negedge clk);
    end
    serial_in = b[4];
    repeat (8) @(negedge clk);
    #2;
    rst = 1'b1;
    serial_in = 1'b1;
    #1;
    n_cmp++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL midrst_active: got %b expected 0", rx_active); end
    n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b expected 0", rx_done); end
    n_cmp++; if (data_byte !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h expected 00", data_byte); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL midrst_abort_done: got %0d expected 0", done_cnt - d0); end
    send_byte(8'h3C, 1'b1, 16);
    repeat (30) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL midrst_next_done: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (data_byte !== 8'h3C) begin n_err++; $display("FAIL midrst_next_data: got %h expected 3c", data_byte); end
  endtask

  task automatic test_min_count;
    int d0;
    count = 8'd1;
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    send_byte(8'h81, 1'b1, 2);
    repeat (20) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL min_count_done: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (data_byte !== 8'h81) begin n_err++; $display("FAIL min_count_data: got %h expected 81", data_byte); end
  endtask

  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    count = 8'd50;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_min_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the number of flip-flop stages on serial_in before any sampling (legal range 2-3).
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 count  input  8  clk cycles per bit period (baud divisor); e.g. 50 -> 500 ns/bit at 100 MHz.
REQ-005 serial_in  input  1  asynchronous serial line, idle high.
REQ-006 rx_active  output  1  high while a frame is in progress.
REQ-007 rx_done  output  1  one-cycle pulse when a valid byte is available.
REQ-008 data_byte  output  8  last correctly received byte.

Function
REQ-009 Frame format SHALL be 8N1: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), no parity.
REQ-010 serial_in SHALL pass through SYNC_STAGES synchronizer flops; all decisions use the synchronized value (rxs).
REQ-011 count SHALL be latched on start detection; the latched value is used for the whole frame; latched values below 2 SHALL be treated as 2.
REQ-012 States SHALL be IDLE, START, DATA, STOP, CLEANUP.
REQ-013 IDLE: on rxs == 0, clear the bit timer, latch count, set rx_active, and go to START.
REQ-014 START: at timer == (count/2)-1, integer division, sample the middle of the start bit; rxs == 0 -> clear timer, go to DATA; rxs == 1 -> false start, go to IDLE with rx_active cleared, no rx_done.
REQ-015 DATA: every count cycles, shift rxs into the bit index (0..7, LSB first); after bit 7 go to STOP.
REQ-016 STOP: after count cycles, sample rxs; 1 -> load data_byte from the shift register, pulse rx_done, go to CLEANUP; 0 -> framing error, data_byte unchanged, no rx_done, go to CLEANUP.
REQ-017 CLEANUP: lasts exactly 1 cycle, clears rx_active, returns to IDLE; a new start is accepted the cycle after entering IDLE.
REQ-018 rx_done SHALL be high for exactly one clk cycle per good frame, concurrent with data_byte already holding the new value.
REQ-019 data_byte SHALL hold its value until the next good frame.
REQ-020 Changes to count mid-frame SHALL have no effect until the next start detection.
REQ-021 A low line held past a framing error SHALL NOT be re-detected as a start until rxs has returned high at least one cycle (break guard).
REQ-022 Timer width SHALL be 8 bits; no wrap occurs because the timer is cleared at every bit boundary.

Reset
REQ-023 rst SHALL asynchronously force: state IDLE, timer 0, bit index 0, shift register 0x00, data_byte 0x00, rx_done 0, rx_active 0, synchronizer flops 1.
REQ-024 rst asserted mid-frame SHALL abort the frame with no rx_done; reception resumes on the first falling edge after rst deasserts.

Configuration
REQ-025 Macro UART_RX_FRAMING_ERR_EN defined: add output framing_err (1 bit), a one-cycle pulse on the stop-bit sample when rxs == 0, reset 0.
REQ-026 Macro UART_RX_FRAMING_ERR_EN undefined: no framing_err port; framing errors are silently dropped; all other behaviour is identical.

Verification
REQ-027 count=50, idle high, send 0x55 at 500 ns/bit -> data_byte=0x55, one rx_done pulse, rx_active high for the frame duration.
REQ-028 count=50, 10 ns low glitch on idle line -> start rejected at mid-bit, no rx_done, rx_active returns low, data_byte unchanged.
REQ-029 count=50, frame 0xA3 with stop bit low -> no rx_done, data_byte keeps its previous value, framing_err pulses (when enabled).
REQ-030 count=16, back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done pulses, data_byte 0x00 then 0xFF.
REQ-031 rst pulsed during data bit 4 -> all outputs 0 immediately; the next full frame 0x3C is received correctly.
REQ-032 count=1 -> treated as 2, frame 0x81 at 2 cycles/bit -> data_byte=0x81 with rx_done.
